cell_comm_link_monitor: RTL and testbench

CELL_COMM_LINK_MONITOR -- requirements
Module: cell_comm_link_monitor

---
 rtl/cell_comm_link_monitor.sv | 165 ++++++++++++++++
 tb/tb_cell_comm_link_monitor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_comm_link_monitor.sv
// cell_comm_link_monitor: per-link Aurora RX statistics monitor.
// Counts good frames, CRC faults, channel-down events and idle timeouts per link.
// It keeps sticky per-link fault flags and offers a strobed, registered read port.
// Optional feature: define CELL_COMM_LINK_MON_TIMEOUT_EN to build the per-link idle watchdog
// and its timeout counter. Without it, statSel=3 reads 0 and timeouts never raise linkFault.
module cell_comm_link_monitor #(
    parameter int unsigned NUM_LINKS      = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned SEL_WIDTH      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 auUserClk,
    input  logic                 auUserReset,
    input  logic [NUM_LINKS-1:0] channelUp,
    input  logic [NUM_LINKS-1:0] rxTvalid,
    input  logic [NUM_LINKS-1:0] rxTlast,
    input  logic [NUM_LINKS-1:0] rxCRCvalid,
    input  logic [NUM_LINKS-1:0] rxCRCpass,
    input  logic [SEL_WIDTH-1:0] linkSel,
    input  logic [1:0]           statSel,
    input  logic                 rdStrobe,
    input  logic                 clrStrobe,
    output logic [CNT_WIDTH-1:0] rdData,
    output logic                 rdValid,
    output logic [NUM_LINKS-1:0] linkFault
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

`ifdef CELL_COMM_LINK_MON_TIMEOUT_EN
    localparam int unsigned          WdWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdWidth-1:0]   WdLast  = WdWidth'(TIMEOUT_CYCLES - 1);
`else
    // Watchdog inputs and its length have no consumer in this build
    logic w_unused_wd;
    assign w_unused_wd = ^{rxTvalid, rxTlast, TIMEOUT_CYCLES};
`endif

    // Flattened view of every counter: [link][statSel]
    logic [CNT_WIDTH-1:0] w_stat [NUM_LINKS][4];
    logic [CNT_WIDTH-1:0] w_rd_sel;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CntMax) ? v : v + CNT_WIDTH'(1);
    endfunction

    for (genvar g = 0; g < NUM_LINKS; g++) begin : g_link
        logic                 w_clr;
        logic                 w_good;
        logic                 w_crc_fault;
        logic                 w_down;
        logic                 w_tmo;
        logic [CNT_WIDTH-1:0] w_tmo_cnt;
        logic                 r_up;
        logic                 r_fault;
        logic [CNT_WIDTH-1:0] r_good;
        logic [CNT_WIDTH-1:0] r_crc;
        logic [CNT_WIDTH-1:0] r_down;

        // linkSel values at or above NUM_LINKS never match, so such clears do nothing
        assign w_clr       = clrStrobe && (linkSel == SEL_WIDTH'(g));
        assign w_good      = rxCRCvalid[g] & rxCRCpass[g];
        assign w_crc_fault = rxCRCvalid[g] & ~rxCRCpass[g];
        // Reset leaves r_up low, so a link already up at reset release is not a down event
        assign w_down      = r_up & ~channelUp[g];

        // Registered channel-up copy used for 1->0 detection; only reset touches it
        always_ff @(posedge auUserClk) begin
            if (auUserReset) begin
                r_up <= 1'b0;
            end else begin
                r_up <= channelUp[g];
            end
        end

        // Frame, CRC-fault and down-event counters plus sticky fault; clear beats any event
        always_ff @(posedge auUserClk) begin
            if (auUserReset || w_clr) begin
                r_good  <= '0;
                r_crc   <= '0;
                r_down  <= '0;
                r_fault <= 1'b0;
            end else begin
                if (w_good) begin
                    r_good <= sat_inc(r_good);
                end
                if (w_crc_fault) begin
                    r_crc <= sat_inc(r_crc);
                end
                if (w_down) begin
                    r_down <= sat_inc(r_down);
                end
                if (w_crc_fault || w_down || w_tmo) begin
                    r_fault <= 1'b1;
                end
            end
        end

`ifdef CELL_COMM_LINK_MON_TIMEOUT_EN
        logic [WdWidth-1:0]   r_wdog;
        logic                 w_wd_hold;
        logic [CNT_WIDTH-1:0] r_tmo;

        // A frame end or a dropped channel restarts the idle count
        assign w_wd_hold = ~channelUp[g] | (rxTvalid[g] & rxTlast[g]);
        assign w_tmo     = ~w_wd_hold & (r_wdog == WdLast);

        // Idle watchdog: counts up while the link is up and quiet, wraps to 0 on a timeout
        always_ff @(posedge auUserClk) begin
            if (auUserReset || w_clr) begin
                r_wdog <= '0;
            end else if (w_wd_hold || w_tmo) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WdWidth'(1);
            end
        end

        // Timeout event counter
        always_ff @(posedge auUserClk) begin
            if (auUserReset || w_clr) begin
                r_tmo <= '0;
            end else if (w_tmo) begin
                r_tmo <= sat_inc(r_tmo);
            end
        end

        assign w_tmo_cnt = r_tmo;
`else
        assign w_tmo     = 1'b0;
        assign w_tmo_cnt = '0;
`endif

        assign w_stat[g][0] = r_good;
        assign w_stat[g][1] = r_crc;
        assign w_stat[g][2] = r_down;
        assign w_stat[g][3] = w_tmo_cnt;
        assign linkFault[g] = r_fault;
    end

    // Read mux; an out-of-range linkSel matches no link and yields 0
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            if (linkSel == SEL_WIDTH'(i)) begin
                w_rd_sel = w_stat[i][statSel];
            end
        end
    end

    // Read port: samples pre-clear counter state, so a same-cycle clear returns the old value
    always_ff @(posedge auUserClk) begin
        if (auUserReset) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdStrobe;
            if (rdStrobe) begin
                rdData <= w_rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_cell_comm_link_monitor.sv
// Self-checking bench for cell_comm_link_monitor: vector table, directed corner
// sequences and a randomized run against a behavioural model of the monitor.
module tb_cell_comm_link_monitor;

    localparam int NL   = 2;
    localparam int CW   = 8;
    localparam int SW   = 3;
    localparam int TO   = 16;
    localparam int CMAX = 255;
`ifdef CELL_COMM_LINK_MON_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] up, tv, tl, cv, cp;
    logic [SW-1:0] sel;
    logic [1:0]    st;
    logic          rd, clr;
    logic [CW-1:0] rdData;
    logic          rdValid;
    logic [NL-1:0] fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_cnt [NL][4];
    bit m_fault [NL];
    int m_idle [NL];
    bit m_up [NL];
    int m_rd_data;
    bit m_rd_valid;

    always #5 clk = ~clk;

    cell_comm_link_monitor #(
        .NUM_LINKS      (NL),
        .CNT_WIDTH      (CW),
        .SEL_WIDTH      (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .auUserClk   (clk),
        .auUserReset (rst),
        .channelUp   (up),
        .rxTvalid    (tv),
        .rxTlast     (tl),
        .rxCRCvalid  (cv),
        .rxCRCpass   (cp),
        .linkSel     (sel),
        .statSel     (st),
        .rdStrobe    (rd),
        .clrStrobe   (clr),
        .rdData      (rdData),
        .rdValid     (rdValid),
        .linkFault   (fault)
    );

    typedef struct {
        logic [1:0] up, tv, tl, cv, cp;
        logic       rd, clr;
        logic [2:0] sel;
        logic [1:0] st;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ef;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [1:0] u, logic [1:0] c_v, logic [1:0] c_p, logic r,
                                logic c, logic [2:0] s, logic [1:0] t, logic e_v,
                                logic [7:0] e_d, logic [1:0] e_f);
        vec_t v;
        v.up = u; v.tv = 2'b11; v.tl = 2'b11; v.cv = c_v; v.cp = c_p;
        v.rd = r; v.clr = c; v.sel = s; v.st = t;
        v.ev = e_v; v.ed = e_d; v.ef = e_f;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs, then clock the DUT
    task automatic tick();
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                for (int k = 0; k < 4; k++) m_cnt[l][k] = 0;
                m_fault[l] = 0;
                m_idle[l]  = 0;
                m_up[l]    = 0;
            end
            m_rd_data  = 0;
            m_rd_valid = 0;
        end else begin
            m_rd_valid = rd;
            if (rd) m_rd_data = (int'(sel) < NL) ? m_cnt[int'(sel)][st] : 0;
            for (int l = 0; l < NL; l++) begin
                bit ev [4];
                ev[0] = cv[l] && cp[l];
                ev[1] = cv[l] && !cp[l];
                ev[2] = m_up[l] && !up[l];
                ev[3] = 0;
                if (TmoEn) begin
                    if (!up[l] || (tv[l] && tl[l])) begin
                        m_idle[l] = 0;
                    end else begin
                        m_idle[l]++;
                        if (m_idle[l] == TO) begin
                            ev[3] = 1;
                            m_idle[l] = 0;
                        end
                    end
                end
                if (clr && int'(sel) == l) begin
                    for (int k = 0; k < 4; k++) m_cnt[l][k] = 0;
                    m_fault[l] = 0;
                    m_idle[l]  = 0;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (ev[k]) m_cnt[l][k] = (m_cnt[l][k] < CMAX) ? m_cnt[l][k] + 1 : CMAX;
                    if (ev[1] || ev[2] || ev[3]) m_fault[l] = 1;
                end
                m_up[l] = up[l];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cv = '0; cp = '0; rd = 1'b0; clr = 1'b0; sel = '0; st = '0;
    endtask

    task automatic do_reset(logic [1:0] up_val);
        rst = 1'b1;
        quiet();
        up = up_val; tv = 2'b11; tl = 2'b11;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic read_chk(string name, int link, int stat, int exp);
        rd = 1'b1; sel = SW'(link); st = 2'(stat);
        tick();
        rd = 1'b0;
        check({name, "_valid"}, rdValid, 1);
        check({name, "_data"}, rdData, exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Vector table: expected outputs are hand-derived, applied from a fresh reset
        tbl[0]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[1]  = mk(2'b11, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[2]  = mk(2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01);
        tbl[3]  = mk(2'b11, 2'b10, 2'b10, 1, 0, 0, 0, 1, 1, 2'b01);
        tbl[4]  = mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 1, 1, 1, 2'b01);
        tbl[5]  = mk(2'b11, 2'b00, 2'b00, 1, 0, 1, 0, 1, 1, 2'b01);
        tbl[6]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b01);
        tbl[7]  = mk(2'b11, 2'b00, 2'b00, 1, 0, 5, 0, 1, 0, 2'b01);
        tbl[8]  = mk(2'b11, 2'b01, 2'b00, 1, 1, 0, 1, 1, 1, 2'b00);
        tbl[9]  = mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 2'b00);
        tbl[10] = mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 2'b00);
        tbl[11] = mk(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01);
        tbl[12] = mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 2, 1, 1, 2'b01);
        tbl[13] = mk(2'b11, 2'b00, 2'b00, 1, 1, 6, 2, 1, 0, 2'b01);
        tbl[14] = mk(2'b11, 2'b00, 2'b00, 1, 0, 0, 2, 1, 1, 2'b01);
        tbl[15] = mk(2'b11, 2'b00, 2'b00, 1, 0, 1, 0, 1, 1, 2'b01);

        do_reset(2'b11);
        check("reset_valid", rdValid, 0);
        check("reset_data", rdData, 0);
        check("reset_fault", fault, 0);

        for (int i = 0; i < 16; i++) begin
            up = tbl[i].up; tv = tbl[i].tv; tl = tbl[i].tl;
            cv = tbl[i].cv; cp = tbl[i].cp; rd = tbl[i].rd; clr = tbl[i].clr;
            sel = tbl[i].sel; st = tbl[i].st;
            tick();
            check($sformatf("tbl%0d_valid", i), rdValid, tbl[i].ev);
            check($sformatf("tbl%0d_data", i), rdData, tbl[i].ed);
            check($sformatf("tbl%0d_fault", i), fault, tbl[i].ef);
        end
        quiet();

        // 5 good and 2 failing CRC strobes on link 0
        do_reset(2'b11);
        for (int i = 0; i < 7; i++) begin
            cv = 2'b01; cp = (i < 5) ? 2'b01 : 2'b00;
            tick();
        end
        quiet();
        read_chk("crc_good", 0, 0, 5);
        read_chk("crc_bad", 0, 1, 2);
        check("crc_fault_flags", fault, 2'b01);

        // Saturation: 300 good frames on link 1
        for (int i = 0; i < 300; i++) begin
            cv = 2'b10; cp = 2'b10;
            tick();
        end
        quiet();
        read_chk("sat_good", 1, 0, CMAX);

        // Channel up through reset release counts nothing; then three down toggles
        do_reset(2'b11);
        tick();
        read_chk("down_at_reset", 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            up = 2'b10; tick();
            up = 2'b11; tick();
        end
        read_chk("down_three", 0, 2, 3);
        check("down_fault_flags", fault, 2'b01);

        // Idle link 0 for 40 cycles; link 1 keeps ending frames
        do_reset(2'b11);
        tv = 2'b10; tl = 2'b10;
        for (int i = 0; i < 40; i++) tick();
        tv = 2'b11; tl = 2'b11;
        check("tmo_fault_flags", fault, TmoEn ? 2'b01 : 2'b00);
        read_chk("tmo_count", 0, 3, TmoEn ? 2 : 0);
        read_chk("tmo_link1", 1, 3, 0);

        // Clear, CRC fault and read all hit link 1 in one cycle
        do_reset(2'b11);
        for (int i = 0; i < 2; i++) begin
            cv = 2'b10; cp = 2'b00; tick();
        end
        cv = 2'b10; cp = 2'b00; clr = 1'b1; rd = 1'b1; sel = 3'd1; st = 2'd1;
        tick();
        quiet();
        check("clr_old_valid", rdValid, 1);
        check("clr_old_data", rdData, 2);
        check("clr_fault_low", fault, 2'b00);
        read_chk("clr_after", 1, 1, 0);

        // Out-of-range read pulses once with zero data and disturbs nothing
        cv = 2'b01; cp = 2'b01; tick(); quiet();
        read_chk("oor_read", 5, 0, 0);
        tick();
        check("oor_single_pulse", rdValid, 0);
        read_chk("oor_keep_good0", 0, 0, 1);

        // Strobes coincident with reset are ignored
        rst = 1'b1; rd = 1'b1; clr = 1'b1; sel = '0; st = '0;
        tick();
        check("rst_strobe_valid", rdValid, 0);
        check("rst_strobe_data", rdData, 0);
        rst = 1'b0;
        quiet();

        // Randomized run against the model
        do_reset(2'b11);
        for (int c = 0; c < 2000; c++) begin
            for (int l = 0; l < NL; l++) begin
                up[l] = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    tv[l] = 1'b1; tl[l] = 1'b1;
                end else begin
                    tv[l] = 1'($urandom_range(0, 1)); tl[l] = 1'b0;
                end
                cv[l] = ($urandom_range(0, 2) == 0);
                cp[l] = 1'($urandom_range(0, 1));
            end
            rd  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 24) == 0);
            sel = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 7))
                                              : SW'($urandom_range(0, NL - 1));
            st  = 2'($urandom_range(0, 3));
            tick();
            check("rand_valid", rdValid, m_rd_valid);
            check("rand_data", rdData, m_rd_data);
            check("rand_fault", fault, {m_fault[1], m_fault[0]});
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
